// File: rtl/sccb_cfg_pkg.sv
// Shared types, constants and the default camera register list
// for the SCCB configuration sequencer.
package sccb_cfg_pkg;

    localparam logic [7:0] CFG_END_ADDR   = 8'hFF;
    localparam logic [7:0] CFG_END_DATA   = 8'hFF;
    localparam logic [7:0] CFG_DELAY_ADDR = 8'hF0;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT,
        ST_DELAY
    } cfg_state_e;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } cfg_entry_t;

    // Soft reset first, then settle before the mode and format registers.
    function automatic cfg_entry_t camera_entry(input int unsigned idx);
        cfg_entry_t e;
        case (idx)
            0:       e = '{addr: 8'h12, data: 8'h80};
            1:       e = '{addr: CFG_DELAY_ADDR, data: 8'h0A};
            2:       e = '{addr: 8'h12, data: 8'h04};
            3:       e = '{addr: 8'h11, data: 8'h01};
            4:       e = '{addr: 8'h0C, data: 8'h00};
            5:       e = '{addr: 8'h3E, data: 8'h00};
            6:       e = '{addr: 8'h40, data: 8'hD0};
            7:       e = '{addr: 8'h8C, data: 8'h00};
            8:       e = '{addr: 8'h3A, data: 8'h04};
            9:       e = '{addr: 8'h14, data: 8'h18};
            default: e = '{addr: CFG_END_ADDR, data: CFG_END_DATA};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/sccb_config_rom.sv
// Synchronous-read register table; either the built-in camera list
// or a caller-supplied packed table (entry 0 in the low 16 bits).
module sccb_config_rom
    import sccb_cfg_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 128,
    parameter int unsigned IDX_W       = 7,
    parameter bit          USE_INIT    = 1'b0,
    parameter logic [16*NUM_ENTRIES-1:0] INIT_TABLE = '0
) (
    input  logic             clk_i,
    input  logic [IDX_W-1:0] addr_i,
    output logic [15:0]      data_o
);

    logic [15:0] rd_d;
    logic [15:0] data_q;

    always_comb begin
        rd_d = '0;
        if (USE_INIT) begin
            rd_d = INIT_TABLE[{addr_i, 4'b0000} +: 16];
        end else begin
            rd_d = camera_entry(32'(addr_i));
        end
    end

    always_ff @(posedge clk_i) begin
        data_q <= rd_d;
    end

    assign data_o = data_q;

endmodule

// File: rtl/sccb_config_sequencer.sv
// Walks the register table, one SCCB write per entry, with timeout.
// Define SCCB_CFG_DELAY_EN to treat address F0 entries as ms delays.
module sccb_config_sequencer
    import sccb_cfg_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 25_000_000,
    parameter int unsigned NUM_ENTRIES    = 128,
    parameter int unsigned POWERUP_CYCLES = 25_000,
    parameter int unsigned TIMEOUT_CYCLES = 50_000,
    parameter bit          AUTO_START     = 1'b1,
    parameter bit          USE_INIT       = 1'b0,
    parameter logic [16*NUM_ENTRIES-1:0] INIT_TABLE = '0,
    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             transmit,
    output logic [7:0]       address,
    output logic [7:0]       write_data,
    input  logic             sccb_done,
    output logic             busy,
    output logic             config_done,
    output logic             error,
    output logic [IDX_W-1:0] entry_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    cfg_state_e       state_q, state_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             adv;
    cfg_entry_t       rom_q;

`ifdef SCCB_CFG_DELAY_EN
    localparam int unsigned MS_CYCLES = CLK_FREQ_HZ / 1000;
    logic [31:0] dly_lim_q, dly_lim_d;
`endif

    sccb_config_rom #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .IDX_W       (IDX_W),
        .USE_INIT    (USE_INIT),
        .INIT_TABLE  (INIT_TABLE)
    ) u_rom (
        .clk_i  (clk),
        .addr_i (idx_q),
        .data_o (rom_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = done_q;
        err_d   = err_q;
        adv     = 1'b0;
`ifdef SCCB_CFG_DELAY_EN
        dly_lim_d = dly_lim_q;
`endif
        unique case (state_q)
            ST_PWRUP: begin
                if (cnt_q + 32'd1 >= POWERUP_CYCLES) begin
                    state_d = AUTO_START ? ST_FETCH : ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                if (rom_q.addr == CFG_END_ADDR && rom_q.data == CFG_END_DATA) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
`ifdef SCCB_CFG_DELAY_EN
                end else if (rom_q.addr == CFG_DELAY_ADDR) begin
                    state_d   = ST_DELAY;
                    dly_lim_d = 32'(rom_q.data) * MS_CYCLES;
`endif
                end else begin
                    addr_d  = rom_q.addr;
                    data_d  = rom_q.data;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (sccb_done) begin
                    adv = 1'b1;
                end else if (cnt_q + 32'd1 >= TIMEOUT_CYCLES) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
`ifdef SCCB_CFG_DELAY_EN
            ST_DELAY: begin
                // A zero-length delay still spends one cycle here.
                if (cnt_q + 32'd1 >= dly_lim_q) begin
                    adv = 1'b1;
                end
            end
`endif
            default: state_d = ST_PWRUP;
        endcase

        // The last slot ends the walk even without an end marker.
        if (adv) begin
            if (idx_q == LAST_IDX) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = ST_FETCH;
            end
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_PWRUP;
            cnt_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef SCCB_CFG_DELAY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_lim_q <= '0;
        end else begin
            dly_lim_q <= dly_lim_d;
        end
    end
`endif

    assign transmit    = (state_q == ST_ISSUE);
    assign address     = addr_q;
    assign write_data  = data_q;
    assign busy        = (state_q != ST_IDLE) && (AUTO_START || state_q != ST_PWRUP);
    assign config_done = done_q;
    assign error       = err_q;
    assign entry_idx   = idx_q;

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Directed bench: three sequencer instances with small tables
// (normal run/timeout/reset, no end marker, F0 entry).
module tb_sccb_config_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  start;
    logic [2:0]  done;
    logic [2:0]  tx;
    logic [2:0]  busy;
    logic [2:0]  cfg;
    logic [2:0]  err;
    logic [2:0]  resp_en;
    logic [7:0]  ad [3];
    logic [7:0]  wd [3];
    logic [1:0]  idx [3];
    logic [15:0] txlog [3][$];
    int          first_cyc [3];
    int          cyc = 0;
    int          rel_cyc;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    sccb_config_sequencer #(
        .CLK_FREQ_HZ(25_000_000), .NUM_ENTRIES(4), .POWERUP_CYCLES(20),
        .TIMEOUT_CYCLES(100), .AUTO_START(1'b1), .USE_INIT(1'b1),
        .INIT_TABLE(64'h0000_FFFF_1101_1280)
    ) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .transmit(tx[0]),
        .address(ad[0]), .write_data(wd[0]), .sccb_done(done[0]),
        .busy(busy[0]), .config_done(cfg[0]), .error(err[0]),
        .entry_idx(idx[0])
    );

    sccb_config_sequencer #(
        .CLK_FREQ_HZ(25_000_000), .NUM_ENTRIES(4), .POWERUP_CYCLES(20),
        .TIMEOUT_CYCLES(100), .AUTO_START(1'b0), .USE_INIT(1'b1),
        .INIT_TABLE(64'h3E19_0C04_1101_1280)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .transmit(tx[1]),
        .address(ad[1]), .write_data(wd[1]), .sccb_done(done[1]),
        .busy(busy[1]), .config_done(cfg[1]), .error(err[1]),
        .entry_idx(idx[1])
    );

    sccb_config_sequencer #(
        .CLK_FREQ_HZ(1_000_000), .NUM_ENTRIES(4), .POWERUP_CYCLES(20),
        .TIMEOUT_CYCLES(100), .AUTO_START(1'b1), .USE_INIT(1'b1),
        .INIT_TABLE(64'hFFFF_FFFF_1280_F002)
    ) u_dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .transmit(tx[2]),
        .address(ad[2]), .write_data(wd[2]), .sccb_done(done[2]),
        .busy(busy[2]), .config_done(cfg[2]), .error(err[2]),
        .entry_idx(idx[2])
    );

    // Downstream model: log each write, answer sccb_done 10 cycles later.
    initial begin
        int cnt [3];
        done = '0;
        for (int g = 0; g < 3; g++) begin
            cnt[g] = 0;
            first_cyc[g] = -1;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                done[g] = 1'b0;
                if (rst) cnt[g] = 0;
                if (cnt[g] > 0) begin
                    cnt[g] = cnt[g] - 1;
                    if (cnt[g] == 0) done[g] = 1'b1;
                end
                if (tx[g]) begin
                    txlog[g].push_back({ad[g], wd[g]});
                    if (first_cyc[g] < 0) first_cyc[g] = cyc;
                    if (resp_en[g]) cnt[g] = 9;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input int g);
        @(negedge clk);
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
    endtask

    task automatic wait_end(input int g, input int lim);
        int n = 0;
        while (!cfg[g] && !err[g] && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("wait_end%0d", g), 32'(n < lim), 1);
    endtask

    task automatic wait_tx(input int g, input int lim);
        int n = 0;
        while (!tx[g] && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("wait_tx%0d", g), 32'(n < lim), 1);
    endtask

    initial begin
        rst     = 1'b1;
        start   = '0;
        resp_en = 3'b111;
        repeat (3) @(negedge clk);

        chk("rst_transmit", tx[0], 0);
        chk("rst_address", ad[0], 0);
        chk("rst_wdata", wd[0], 0);
        chk("rst_idx", idx[0], 0);
        chk("rst_cfg", cfg[0], 0);
        chk("rst_err", err[0], 0);
        chk("rst_busy_auto", busy[0], 1);
        chk("rst_busy_manual", busy[1], 0);

        rst = 1'b0;
        rel_cyc = cyc;

        wait_end(0, 500);
        chk("run_count", txlog[0].size(), 2);
        chk("run_w0", txlog[0][0], 16'h1280);
        chk("run_w1", txlog[0][1], 16'h1101);
        chk("run_cfg", cfg[0], 1);
        chk("run_busy", busy[0], 0);
        chk("run_err", err[0], 0);
        chk("run_idx", idx[0], 2);

        chk("man_idle_busy", busy[1], 0);
        chk("man_idle_tx", txlog[1].size(), 0);
        pulse_start(1);
        chk("man_lat_fetch", tx[1], 0);
        @(negedge clk);
        chk("man_lat_decode", tx[1], 0);
        @(negedge clk);
        chk("man_lat_issue", tx[1], 1);
        wait_end(1, 500);
        chk("nomark_count", txlog[1].size(), 4);
        chk("nomark_w2", txlog[1][2], 16'h0C04);
        chk("nomark_w3", txlog[1][3], 16'h3E19);
        chk("nomark_cfg", cfg[1], 1);
        chk("nomark_idx", idx[1], 3);
        chk("nomark_busy", busy[1], 0);

        wait_end(2, 3000);
        chk("f0_cfg", cfg[2], 1);
`ifdef SCCB_CFG_DELAY_EN
        chk("f0_delay_count", txlog[2].size(), 1);
        chk("f0_delay_w0", txlog[2][0], 16'h1280);
        chk("f0_delay_time", 32'((first_cyc[2] - rel_cyc >= 2000) &&
                                 (first_cyc[2] - rel_cyc < 2100)), 1);
`else
        chk("f0_plain_count", txlog[2].size(), 2);
        chk("f0_plain_w0", txlog[2][0], 16'hF002);
        chk("f0_plain_w1", txlog[2][1], 16'h1280);
        chk("f0_plain_time", 32'(first_cyc[2] - rel_cyc < 100), 1);
`endif

        resp_en[0] = 1'b0;
        txlog[0].delete();
        pulse_start(0);
        chk("to_cfg_clear", cfg[0], 0);
        wait_tx(0, 20);
        repeat (100) @(negedge clk);
        chk("to_err_early", err[0], 0);
        @(negedge clk);
        chk("to_err", err[0], 1);
        chk("to_idx", idx[0], 0);
        chk("to_busy", busy[0], 0);
        chk("to_cfg", cfg[0], 0);
        repeat (30) @(negedge clk);
        chk("to_no_more_tx", txlog[0].size(), 1);

        resp_en[0] = 1'b1;
        txlog[0].delete();
        pulse_start(0);
        chk("rs_err_clear", err[0], 0);
        chk("rs_busy", busy[0], 1);
        repeat (5) @(negedge clk);
        pulse_start(0);
        wait_end(0, 500);
        chk("rs_count", txlog[0].size(), 2);
        chk("rs_w0", txlog[0][0], 16'h1280);
        chk("rs_w1", txlog[0][1], 16'h1101);
        chk("rs_cfg", cfg[0], 1);
        chk("rs_err", err[0], 0);

        txlog[0].delete();
        pulse_start(0);
        wait_tx(0, 20);
        repeat (12) @(negedge clk);
        wait_tx(0, 20);
        repeat (3) @(negedge clk);
        chk("mid_pre_addr", ad[0], 8'h11);
        #2 rst = 1'b1;
        #1;
        chk("mid_tx", tx[0], 0);
        chk("mid_addr", ad[0], 0);
        chk("mid_wdata", wd[0], 0);
        chk("mid_idx", idx[0], 0);
        chk("mid_busy", busy[0], 1);
        chk("mid_cfg", cfg[0], 0);
        chk("mid_err", err[0], 0);
        @(negedge clk);
        txlog[0].delete();
        rst = 1'b0;
        wait_end(0, 500);
        chk("replay_count", txlog[0].size(), 2);
        chk("replay_w0", txlog[0][0], 16'h1280);
        chk("replay_cfg", cfg[0], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
